// File: rtl/cache_read_controller.sv
// Read-side controller for a direct-mapped, 1024-line, 4-word-per-line cache.
// It accepts one CPU load at a time and looks the address up in the external
// tag/valid/line array. On a miss it fetches the line from main memory and
// writes it into the array. It then returns the addressed word with a
// one-cycle cpuReady pulse. It also keeps saturating hit and miss counters.
module cache_read_controller #(
    parameter int ADDR_WIDTH  = 15,
    parameter int INDEX_WIDTH = 10,
    parameter int TAG_WIDTH   = 3,
    parameter int WORD_SIZE   = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int COUNT_WIDTH = 14
) (
    input  logic                              clk,
    input  logic                              rst,

    // CPU load port
    input  logic                              cpuRead,
    input  logic [ADDR_WIDTH-1:0]             cpuAddress,
    output logic                              cpuReady,
    output logic                              cpuHit,
    output logic [WORD_SIZE-1:0]              dataOut,

    // Cache array (tag/valid/line storage, combinational read)
    output logic [INDEX_WIDTH-1:0]            cacheIndex,
    input  logic [TAG_WIDTH-1:0]              cacheTagIn,
    input  logic                              cacheValidIn,
    input  logic [LINE_WIDTH-1:0]             cacheLineIn,
    output logic                              cacheWrite,
    output logic [TAG_WIDTH-1:0]              cacheTagOut,
    output logic [LINE_WIDTH-1:0]             cacheLineOut,

    // Main-memory line read port
    output logic                              memRead,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0]  memAddress,
    input  logic                              memReady,
    input  logic [LINE_WIDTH-1:0]             memData,

    // Statistics
    output logic [COUNT_WIDTH-1:0]            hitCount,
    output logic [COUNT_WIDTH-1:0]            missCount
);

    // Address layout: {tag, index, offset}; the offset selects a word in the line.
    localparam int OFFSET_WIDTH    = ADDR_WIDTH - TAG_WIDTH - INDEX_WIDTH;
    localparam int WORDS_PER_LINE  = LINE_WIDTH / WORD_SIZE;
    localparam int LINE_ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_WAIT,
        FILL,
        RESPOND
    } state_t;

    state_t                         state;

    // Request and fill storage
    logic [ADDR_WIDTH-1:0]          addr_q;
    logic [LINE_WIDTH-1:0]          line_q;

    // Registered outputs, each loaded with the value for the state being entered
    logic                           mem_read_q;
    logic                           cache_write_q;
    logic                           cpu_ready_q;
    logic                           cpu_hit_q;
    logic [WORD_SIZE-1:0]           data_out_q;

    logic [COUNT_WIDTH-1:0]         hit_count_q;
    logic [COUNT_WIDTH-1:0]         miss_count_q;

    // Fields of the latched request
    logic [TAG_WIDTH-1:0]           req_tag;
    logic [INDEX_WIDTH-1:0]         req_index;
    logic [OFFSET_WIDTH-1:0]        req_offset;

    // Word-array views of the array line and of the captured fill line
    logic [WORDS_PER_LINE-1:0][WORD_SIZE-1:0] array_words;
    logic [WORDS_PER_LINE-1:0][WORD_SIZE-1:0] fill_words;

    logic                           lookup_hit;
    logic                           count_hit;
    logic                           count_miss;

    assign req_tag     = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign req_index   = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_offset  = addr_q[OFFSET_WIDTH-1:0];

    assign array_words = cacheLineIn;
    assign fill_words  = line_q;

    // A line that is not valid never hits, even if its stale tag matches.
    assign lookup_hit  = cacheValidIn && (cacheTagIn == req_tag);

    // Exactly one counter moves per accepted request, in the LOOKUP cycle.
    assign count_hit   = (state == LOOKUP) &&  lookup_hit;
    assign count_miss  = (state == LOOKUP) && !lookup_hit;

    // The array and the memory see the latched request, never the live CPU bus.
    assign cacheIndex   = req_index;
    assign cacheTagOut  = req_tag;
    assign cacheLineOut = line_q;
    assign memAddress   = addr_q[ADDR_WIDTH-1 -: LINE_ADDR_WIDTH];

    assign memRead      = mem_read_q;
    assign cacheWrite   = cache_write_q;
    assign cpuReady     = cpu_ready_q;
    assign cpuHit       = cpu_hit_q;
    assign dataOut      = data_out_q;
    assign hitCount     = hit_count_q;
    assign missCount    = miss_count_q;

    // Request sequencing FSM; the outputs are registered with the state they belong to.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would make results depend on statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            mem_read_q    <= 1'b0;
            cache_write_q <= 1'b0;
            cpu_ready_q   <= 1'b0;
            cpu_hit_q     <= 1'b0;
            data_out_q    <= '0;
        end else begin
            // Pulse-type outputs default low and are raised only for the state being entered.
            mem_read_q    <= 1'b0;
            cache_write_q <= 1'b0;
            cpu_ready_q   <= 1'b0;
            cpu_hit_q     <= 1'b0;
            data_out_q    <= '0;

            case (state)
                IDLE: begin
                    if (cpuRead) begin
                        state <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (lookup_hit) begin
                        state       <= RESPOND;
                        cpu_ready_q <= 1'b1;
                        cpu_hit_q   <= 1'b1;
                        data_out_q  <= array_words[req_offset];
                    end else begin
                        state      <= MISS_WAIT;
                        mem_read_q <= 1'b1;
                    end
                end

                MISS_WAIT: begin
                    // memRead stays a level until memory answers; there is no timeout.
                    if (memReady) begin
                        state         <= FILL;
                        cache_write_q <= 1'b1;
                    end else begin
                        mem_read_q <= 1'b1;
                    end
                end

                FILL: begin
                    // The line was captured on entry to FILL, so the word comes from line_q.
                    state       <= RESPOND;
                    cpu_ready_q <= 1'b1;
                    cpu_hit_q   <= 1'b0;
                    data_out_q  <= fill_words[req_offset];
                end

                RESPOND: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Latches the request in IDLE and captures the memory line in MISS_WAIT.
    // NOTE: these are small datapath registers, not an array, so they take the
    // async reset as well.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            line_q <= '0;
        end else begin
            if (state == IDLE && cpuRead) begin
                addr_q <= cpuAddress;
            end
            if (state == MISS_WAIT && memReady) begin
                line_q <= memData;
            end
        end
    end

    // Saturating hit/miss statistics; a counter at all-ones holds its value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (count_hit && !(&hit_count_q)) begin
                hit_count_q <= hit_count_q + COUNT_WIDTH'(1);
            end
            if (count_miss && !(&miss_count_q)) begin
                miss_count_q <= miss_count_q + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_read_controller.sv
// Self-checking bench for cache_read_controller. It models the cache array and
// main memory. It checks directed vectors, back-to-back hits, reset during a
// miss and counter saturation against a high-level model, and it also checks
// randomized reads against that model.
module tb_cache_read_controller;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpuRead;
    logic [14:0]   cpuAddress;
    logic          cpuReady;
    logic          cpuHit;
    logic [31:0]   dataOut;
    logic [9:0]    cacheIndex;
    logic [2:0]    cacheTagIn;
    logic          cacheValidIn;
    logic [127:0]  cacheLineIn;
    logic          cacheWrite;
    logic [2:0]    cacheTagOut;
    logic [127:0]  cacheLineOut;
    logic          memRead;
    logic [12:0]   memAddress;
    logic          memReady;
    logic [127:0]  memData;
    logic [13:0]   hitCount;
    logic [13:0]   missCount;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: which tag each index holds, and the expected statistics.
    logic [2:0] m_tag [int];
    int         exp_hits;
    int         exp_misses;

    // Behavioural cache array storage.
    logic          inv_all;
    logic [2:0]    arr_tag   [1024];
    logic          arr_valid [1024];
    logic [127:0]  arr_line  [1024];

    cache_read_controller dut (
        .clk          (clk),
        .rst          (rst),
        .cpuRead      (cpuRead),
        .cpuAddress   (cpuAddress),
        .cpuReady     (cpuReady),
        .cpuHit       (cpuHit),
        .dataOut      (dataOut),
        .cacheIndex   (cacheIndex),
        .cacheTagIn   (cacheTagIn),
        .cacheValidIn (cacheValidIn),
        .cacheLineIn  (cacheLineIn),
        .cacheWrite   (cacheWrite),
        .cacheTagOut  (cacheTagOut),
        .cacheLineOut (cacheLineOut),
        .memRead      (memRead),
        .memAddress   (memAddress),
        .memReady     (memReady),
        .memData      (memData),
        .hitCount     (hitCount),
        .missCount    (missCount)
    );

    always #5 clk = ~clk;

    assign cacheTagIn   = arr_tag[cacheIndex];
    assign cacheValidIn = arr_valid[cacheIndex];
    assign cacheLineIn  = arr_line[cacheIndex];

    // Array write port; the bench can also clear every valid bit.
    always @(posedge clk) begin
        if (inv_all) begin
            for (int i = 0; i < 1024; i++) begin
                arr_valid[i] <= 1'b0;
                arr_tag[i]   <= 3'd0;
                arr_line[i]  <= '0;
            end
        end else if (cacheWrite) begin
            arr_valid[cacheIndex] <= 1'b1;
            arr_tag[cacheIndex]   <= cacheTagOut;
            arr_line[cacheIndex]  <= cacheLineOut;
        end
    end

    // Main-memory contents. Word n of line address la is a nibble pattern
    // xor'ed with (la-1) in the top bits, so line 1 reads 0x11111111..0x44444444.
    function automatic logic [31:0] mem_word(input logic [12:0] la, input logic [1:0] n);
        logic [3:0]  nib;
        logic [12:0] d;
        nib = {2'b00, n} + 4'd1;
        d   = la - 13'd1;
        return {8{nib}} ^ {d, 19'd0};
    endfunction

    function automatic logic [127:0] mem_line(input logic [12:0] la);
        return {mem_word(la, 2'd3), mem_word(la, 2'd2), mem_word(la, 2'd1), mem_word(la, 2'd0)};
    endfunction

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_counters(input string name);
        check({name, " hitCount"},  128'(hitCount),  128'(exp_hits));
        check({name, " missCount"}, 128'(missCount), 128'(exp_misses));
    endtask

    // One complete read: issues the request, serves memory after mem_delay
    // cycles of memRead, and checks the response against the expected values.
    task automatic run_txn(input string name, input logic [14:0] addr, input int mem_delay,
                           input logic exp_hit, input logic [31:0] exp_data);
        logic [12:0]  la;
        logic         got_ready, got_hit, leak, unstable;
        logic [31:0]  got_data;
        logic [12:0]  mem_addr_seen;
        logic [9:0]   wr_idx;
        logic [2:0]   wr_tag;
        logic [127:0] wr_line;
        int lat, memrd_first, memrd_cycles, ready_cyc, wr_count, wr_cyc;

        la = addr[14:2];
        got_ready = 1'b0; got_hit = 1'b0; leak = 1'b0; unstable = 1'b0;
        got_data = '0; mem_addr_seen = '0; wr_idx = '0; wr_tag = '0; wr_line = '0;
        lat = -1; memrd_first = -1; memrd_cycles = 0; ready_cyc = -1; wr_count = 0; wr_cyc = -1;

        @(negedge clk);
        cpuRead    = 1'b1;
        cpuAddress = addr;
        @(negedge clk);
        // Cycle 1 after acceptance; later bus changes must be ignored.
        cpuRead    = 1'b0;
        cpuAddress = 15'($urandom);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc > 1) @(negedge clk);
            memReady = 1'b0;
            memData  = {$urandom, $urandom, $urandom, $urandom};
            if (cpuReady) begin
                got_ready = 1'b1;
                got_hit   = cpuHit;
                got_data  = dataOut;
                lat       = cyc;
            end else if (cpuHit || dataOut != 32'd0) begin
                leak = 1'b1;
            end
            if (cacheWrite) begin
                wr_count++;
                wr_cyc  = cyc;
                wr_idx  = cacheIndex;
                wr_tag  = cacheTagOut;
                wr_line = cacheLineOut;
            end
            if (memRead) begin
                if (memrd_cycles == 0) begin
                    memrd_first   = cyc;
                    mem_addr_seen = memAddress;
                end else if (memAddress != mem_addr_seen) begin
                    unstable = 1'b1;
                end
                memrd_cycles++;
                if (cyc == memrd_first + mem_delay) begin
                    memReady  = 1'b1;
                    memData   = mem_line(memAddress);
                    ready_cyc = cyc;
                end
            end
            if (got_ready) break;
        end

        check({name, " cpuReady seen"}, 128'(got_ready), 128'(1));
        check({name, " cpuHit"},        128'(got_hit),   128'(exp_hit));
        check({name, " dataOut"},       128'(got_data),  128'(exp_data));
        check({name, " idle outputs"},  128'(leak),      128'(0));
        if (exp_hit) begin
            check({name, " hit latency"},   128'(lat),          128'(2));
            check({name, " memRead cycles"}, 128'(memrd_cycles), 128'(0));
            check({name, " cacheWrite count"}, 128'(wr_count),  128'(0));
            if (exp_hits < 16383) exp_hits++;
        end else begin
            check({name, " memRead start"},   128'(memrd_first),  128'(2));
            check({name, " memRead cycles"},  128'(memrd_cycles), 128'(mem_delay + 1));
            check({name, " memAddress"},      128'(mem_addr_seen), 128'(la));
            check({name, " memAddress stable"}, 128'(unstable),  128'(0));
            check({name, " cacheWrite count"}, 128'(wr_count),   128'(1));
            check({name, " cacheWrite cycle"}, 128'(wr_cyc),     128'(ready_cyc + 1));
            check({name, " miss latency"},    128'(lat),         128'(ready_cyc + 2));
            check({name, " cacheIndex"},      128'(wr_idx),      128'(addr[11:2]));
            check({name, " cacheTagOut"},     128'(wr_tag),      128'(addr[14:12]));
            check({name, " cacheLineOut"},    wr_line,           mem_line(la));
            m_tag[int'(addr[11:2])] = addr[14:12];
            if (exp_misses < 16383) exp_misses++;
        end
        check_counters(name);
    endtask

    // Read whose expected outcome comes from the model and the memory contents.
    task automatic run_model(input string name, input logic [14:0] addr, input int mem_delay);
        logic hit;
        int   idx;
        idx = int'(addr[11:2]);
        hit = m_tag.exists(idx) && (m_tag[idx] == addr[14:12]);
        run_txn(name, addr, mem_delay, hit, mem_word(addr[14:2], addr[1:0]));
    endtask

    typedef struct {
        logic [14:0] addr;
        int          delay;
        logic        hit;
        logic [31:0] data;
    } vec_t;

    task automatic directed_vectors();
        vec_t vecs [9];
        vecs[0] = '{15'h0005, 3, 1'b0, 32'h22222222};
        vecs[1] = '{15'h0005, 0, 1'b1, 32'h22222222};
        vecs[2] = '{15'h1005, 1, 1'b0, 32'h02222222};
        vecs[3] = '{15'h0005, 0, 1'b0, 32'h22222222};
        vecs[4] = '{15'h0006, 0, 1'b1, 32'h33333333};
        vecs[5] = '{15'h0007, 0, 1'b1, 32'h44444444};
        vecs[6] = '{15'h0004, 0, 1'b1, 32'h11111111};
        vecs[7] = '{15'h7FFF, 2, 1'b0, 32'hBBB44444};
        vecs[8] = '{15'h7FFF, 0, 1'b1, 32'hBBB44444};
        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].delay, vecs[i].hit, vecs[i].data);
        end
    endtask

    // cpuRead held high for 10 cycles over two resident lines.
    task automatic back_to_back();
        logic [31:0] b2b_exp [4];
        int   pulses, last;
        logic gap_bad, hit_bad, mem_seen;
        b2b_exp[0] = 32'h22222222;
        b2b_exp[1] = 32'hBBB44444;
        b2b_exp[2] = 32'h22222222;
        b2b_exp[3] = 32'hBBB44444;
        pulses = 0; last = -1; gap_bad = 1'b0; hit_bad = 1'b0; mem_seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (cpuReady) begin
                if (pulses < 4) check($sformatf("b2b data %0d", pulses), 128'(dataOut), 128'(b2b_exp[pulses]));
                if (!cpuHit) hit_bad = 1'b1;
                if (last >= 0 && k - last != 3) gap_bad = 1'b1;
                last = k;
                pulses++;
            end
            if (memRead) mem_seen = 1'b1;
            if (k < 10) begin
                cpuRead    = 1'b1;
                cpuAddress = (k % 2 == 0) ? 15'h0005 : 15'h7FFF;
            end else begin
                cpuRead = 1'b0;
            end
        end
        check("b2b pulses",    128'(pulses),   128'(4));
        check("b2b spacing",   128'(gap_bad),  128'(0));
        check("b2b all hits",  128'(hit_bad),  128'(0));
        check("b2b no memRead", 128'(mem_seen), 128'(0));
        exp_hits += 4;
        check_counters("b2b");
    endtask

    // Reset asserted while a miss waits on memory.
    task automatic reset_mid_miss();
        logic seen, activity;
        seen = 1'b0; activity = 1'b0;
        @(negedge clk);
        cpuRead    = 1'b1;
        cpuAddress = 15'h2008;
        @(negedge clk);
        cpuRead = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (memRead) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst memRead before reset", 128'(seen), 128'(1));
        rst = 1'b0;
        #1;
        exp_hits   = 0;
        exp_misses = 0;
        check("rst memRead drop",   128'(memRead),    128'(0));
        check("rst cacheWrite",     128'(cacheWrite), 128'(0));
        check("rst cpuReady",       128'(cpuReady),   128'(0));
        check_counters("rst");
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b1;
        memReady = 1'b1;
        memData  = mem_line(13'h0802);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            memReady = 1'b0;
            if (memRead || cacheWrite || cpuReady) activity = 1'b1;
        end
        check("rst no activity after release", 128'(activity), 128'(0));
        check_counters("rst after release");
        run_model("rst post-reset read", 15'h0005, 0);
    endtask

    initial begin
        rst        = 1'b0;
        inv_all    = 1'b1;
        cpuRead    = 1'b0;
        cpuAddress = '0;
        memReady   = 1'b0;
        memData    = '0;
        exp_hits   = 0;
        exp_misses = 0;
        repeat (3) @(negedge clk);

        check("reset cpuReady",   128'(cpuReady),   128'(0));
        check("reset cpuHit",     128'(cpuHit),     128'(0));
        check("reset dataOut",    128'(dataOut),    128'(0));
        check("reset cacheWrite", 128'(cacheWrite), 128'(0));
        check("reset memRead",    128'(memRead),    128'(0));
        check_counters("reset");

        inv_all = 1'b0;
        rst     = 1'b1;

        directed_vectors();
        back_to_back();
        reset_mid_miss();

        // Randomized reads over a few indices and two tags, fresh array.
        @(negedge clk);
        inv_all = 1'b1;
        @(negedge clk);
        inv_all = 1'b0;
        m_tag.delete();
        for (int i = 0; i < 40; i++) begin
            logic [14:0] a;
            a = {3'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), 2'($urandom)};
            run_model($sformatf("rand%0d", i), a, int'($urandom_range(0, 4)));
        end

        // Drive hitCount to saturation, then one more hit and one miss.
        for (int i = 0; i < 17000 && exp_hits < 16383; i++) begin
            run_model("sat fill", 15'h0005, 0);
        end
        run_model("sat extra hit", 15'h0005, 0);
        check("sat hitCount held", 128'(hitCount), 128'(16383));
        run_model("sat then miss", 15'h3005, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule
